// File: rtl/swcfg_pkg.sv
// Shared constants and types for the switch configuration loader.
package swcfg_pkg;

    localparam int unsigned SELW     = 6;
    localparam int unsigned SIDE_LSB = 0;
    localparam int unsigned SIDE_W   = 3;
    localparam int unsigned IDX_LSB  = 3;
    localparam int unsigned IDX_W    = 3;

    localparam logic [SIDE_W-1:0] SIDE_NONE   = 3'd0;
    localparam logic [SIDE_W-1:0] SIDE_TOP    = 3'd1;
    localparam logic [SIDE_W-1:0] SIDE_RIGHT  = 3'd2;
    localparam logic [SIDE_W-1:0] SIDE_BOTTOM = 3'd3;
    localparam logic [SIDE_W-1:0] SIDE_LEFT   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERR    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/swcfg_word_check.sv
// Combinational legality check of one routing word against the matrix size.
module swcfg_word_check
    import swcfg_pkg::*;
#(
    parameter int unsigned NTOP  = 5,
    parameter int unsigned NSIDE = 4
) (
    input  logic [SELW-1:0] i_word,
    output logic            o_legal_c
);

    localparam logic [IDX_W:0] NTOP_L  = (IDX_W+1)'(NTOP);
    localparam logic [IDX_W:0] NSIDE_L = (IDX_W+1)'(NSIDE);

    logic [SIDE_W-1:0] w_side;
    logic [IDX_W:0]    w_idx;

    assign w_side = i_word[SIDE_LSB +: SIDE_W];
    assign w_idx  = {1'b0, i_word[IDX_LSB +: IDX_W]};

    // Side 0 never drives, so its index is don't-care; sides 5..7 do not exist.
    always_comb begin
        o_legal_c = 1'b0;
        case (w_side)
            SIDE_NONE:              o_legal_c = 1'b1;
            SIDE_TOP, SIDE_BOTTOM:  o_legal_c = (w_idx < NTOP_L);
            SIDE_RIGHT, SIDE_LEFT:  o_legal_c = (w_idx < NSIDE_L);
            default:                o_legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/switch_cfg_loader.sv
// Serial configuration loader for the 2-side-pair switch matrix.
// Shifts in a bit-serial frame of routing words, validates each word and
// commits the whole set atomically; rejected frames keep the old config.
// Optional macro CFG_PARITY_EN: frame carries a trailing even-parity bit.
module switch_cfg_loader
    import swcfg_pkg::*;
#(
    parameter int unsigned NTOP  = 5,
    parameter int unsigned NSIDE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_valid,
    input  logic                  cfg_din,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic [NTOP*SELW-1:0]  cfg_top,
    output logic [NTOP*SELW-1:0]  cfg_bottom,
    output logic [NSIDE*SELW-1:0] cfg_left,
    output logic [NSIDE*SELW-1:0] cfg_right
);

    localparam int unsigned NWORDS     = 2*NTOP + 2*NSIDE;
    localparam int unsigned FRAME_BITS = NWORDS*SELW;
`ifdef CFG_PARITY_EN
    localparam int unsigned TOTAL_BITS = FRAME_BITS + 1;
`else
    localparam int unsigned TOTAL_BITS = FRAME_BITS;
`endif
    localparam int unsigned CNT_W = $clog2(TOTAL_BITS + 1);
    localparam int unsigned BP_W  = $clog2(SELW);

    loader_state_t r_state;
    loader_state_t w_next;

    logic [CNT_W-1:0]      r_cnt;
    logic [BP_W-1:0]       r_bitpos;
    logic [FRAME_BITS-1:0] r_shadow;
    logic                  r_bad;
`ifdef CFG_PARITY_EN
    logic                  r_par;
`endif

    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [NTOP*SELW-1:0]  r_top;
    logic [NTOP*SELW-1:0]  r_bottom;
    logic [NSIDE*SELW-1:0] r_left;
    logic [NSIDE*SELW-1:0] r_right;

    logic                  w_start_take;
    logic                  w_accept;
    logic                  w_payload;
    logic                  w_shift;
    logic                  w_last;
    logic [SELW-1:0]       w_word;
    logic                  w_word_done;
    logic                  w_word_legal;
    logic                  w_bad_now;
    logic                  w_frame_bad;
    logic [NTOP*SELW-1:0]  w_top;
    logic [NTOP*SELW-1:0]  w_bottom;
    logic [NSIDE*SELW-1:0] w_left;
    logic [NSIDE*SELW-1:0] w_right;

    // A start during the one-cycle commit is dropped; a start always wins over data.
    assign w_start_take = cfg_start && (r_state != ST_COMMIT);
    assign w_accept     = (r_state == ST_LOAD) && cfg_valid && !cfg_start;
    assign w_payload    = (r_cnt < CNT_W'(FRAME_BITS));
    assign w_shift      = w_accept && w_payload;
    assign w_last       = w_accept && (r_cnt == CNT_W'(TOTAL_BITS - 1));
    assign w_word       = {r_shadow[SELW-2:0], cfg_din};
    assign w_word_done  = w_shift && (r_bitpos == BP_W'(SELW - 1));
    assign w_bad_now    = r_bad | (w_word_done & ~w_word_legal);
`ifdef CFG_PARITY_EN
    assign w_frame_bad  = r_bad | (cfg_din ^ r_par);
`else
    assign w_frame_bad  = w_bad_now;
`endif

    swcfg_word_check #(
        .NTOP  (NTOP),
        .NSIDE (NSIDE)
    ) u_word_check (
        .i_word    (w_word),
        .o_legal_c (w_word_legal)
    );

    // The first word sent ends up in the most significant slot of the shadow.
    for (genvar i = 0; i < NTOP; i++) begin : g_tb_words
        assign w_top[i*SELW +: SELW]    = r_shadow[(NWORDS-1-i)*SELW +: SELW];
        assign w_bottom[i*SELW +: SELW] = r_shadow[(NWORDS-1-NTOP-i)*SELW +: SELW];
    end
    for (genvar i = 0; i < NSIDE; i++) begin : g_lr_words
        assign w_left[i*SELW +: SELW]   = r_shadow[(NWORDS-1-2*NTOP-i)*SELW +: SELW];
        assign w_right[i*SELW +: SELW]  = r_shadow[(NWORDS-1-2*NTOP-NSIDE-i)*SELW +: SELW];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (cfg_start) w_next = ST_LOAD;
            ST_LOAD: begin
                if (cfg_start)   w_next = ST_LOAD;
                else if (w_last) w_next = w_frame_bad ? ST_ERR : ST_COMMIT;
            end
            ST_COMMIT: w_next = ST_IDLE;
            ST_ERR:    if (cfg_start) w_next = ST_LOAD;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Frame shift register, bit counters and running word/parity status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_bitpos <= '0;
            r_shadow <= '0;
            r_bad    <= 1'b0;
`ifdef CFG_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else if (w_start_take) begin
            r_cnt    <= '0;
            r_bitpos <= '0;
            r_bad    <= 1'b0;
`ifdef CFG_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_shift) begin
                r_shadow <= {r_shadow[FRAME_BITS-2:0], cfg_din};
                r_bitpos <= w_word_done ? '0 : r_bitpos + BP_W'(1);
                r_bad    <= w_bad_now;
`ifdef CFG_PARITY_EN
                r_par    <= r_par ^ cfg_din;
`endif
            end
        end
    end

    // Status flags and the committed configuration seen by the matrix.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_top    <= '0;
            r_bottom <= '0;
            r_left   <= '0;
            r_right  <= '0;
        end else begin
            r_busy <= (w_next == ST_LOAD) || (w_next == ST_COMMIT);
            r_done <= (r_state == ST_COMMIT);
            r_err  <= (w_next == ST_ERR);
            if (r_state == ST_COMMIT) begin
                r_top    <= w_top;
                r_bottom <= w_bottom;
                r_left   <= w_left;
                r_right  <= w_right;
            end
        end
    end

    assign cfg_busy   = r_busy;
    assign cfg_done   = r_done;
    assign cfg_err    = r_err;
    assign cfg_top    = r_top;
    assign cfg_bottom = r_bottom;
    assign cfg_left   = r_left;
    assign cfg_right  = r_right;

endmodule

// File: tb/tb_switch_cfg_loader.sv
// Randomized self-checking bench for switch_cfg_loader with a word-list model.
// Honors CFG_PARITY_EN the same way the design does.
module tb_switch_cfg_loader;

    localparam int NTOP  = 5;
    localparam int NSIDE = 4;
    localparam int NW    = 2*NTOP + 2*NSIDE;

    typedef logic [5:0] frame_t [NW];

    logic clk = 1'b0;
    logic rst, cfg_start, cfg_valid, cfg_din;
    logic cfg_busy, cfg_done, cfg_err;
    logic [NTOP*6-1:0]  cfg_top, cfg_bottom;
    logic [NSIDE*6-1:0] cfg_left, cfg_right;

    logic [NTOP*6-1:0]  exp_top, exp_bottom;
    logic [NSIDE*6-1:0] exp_left, exp_right;

    int n_checks = 0;
    int n_fail   = 0;

    switch_cfg_loader #(.NTOP(NTOP), .NSIDE(NSIDE)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_din(cfg_din), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .cfg_top(cfg_top), .cfg_bottom(cfg_bottom),
        .cfg_left(cfg_left), .cfg_right(cfg_right)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Legality straight from the side-code table.
    function automatic bit word_ok(input logic [5:0] w);
        int side, idx;
        side = int'(w[2:0]);
        idx  = int'(w[5:3]);
        if (side == 0) return 1'b1;
        if (side == 1 || side == 3) return idx < NTOP;
        if (side == 2 || side == 4) return idx < NSIDE;
        return 1'b0;
    endfunction

    function automatic frame_t rand_frame(input bit allow_bad);
        frame_t f;
        int side, idx;
        for (int k = 0; k < NW; k++) begin
            side = int'($urandom_range(4));
            if (side == 0)                    idx = int'($urandom_range(7));
            else if (side == 1 || side == 3)  idx = int'($urandom_range(NTOP-1));
            else                              idx = int'($urandom_range(NSIDE-1));
            f[k] = {3'(idx), 3'(side)};
            if (allow_bad && $urandom_range(39) == 0) f[k] = 6'($urandom);
        end
        if (allow_bad && $urandom_range(2) == 0)
            f[$urandom_range(NW-1)] = {3'($urandom_range(7)), 3'(5 + $urandom_range(2))};
        return f;
    endfunction

    function automatic frame_t zero_frame();
        frame_t f;
        for (int k = 0; k < NW; k++) f[k] = 6'd0;
        return f;
    endfunction

    task automatic chk_buses(input string tag);
        chk({tag, "_top"},    64'(cfg_top),    64'(exp_top));
        chk({tag, "_bottom"}, 64'(cfg_bottom), 64'(exp_bottom));
        chk({tag, "_left"},   64'(cfg_left),   64'(exp_left));
        chk({tag, "_right"},  64'(cfg_right),  64'(exp_right));
    endtask

    task automatic model_commit(input frame_t f);
        for (int i = 0; i < NTOP; i++) begin
            exp_top[i*6 +: 6]    = f[i];
            exp_bottom[i*6 +: 6] = f[NTOP + i];
        end
        for (int i = 0; i < NSIDE; i++) begin
            exp_left[i*6 +: 6]  = f[2*NTOP + i];
            exp_right[i*6 +: 6] = f[2*NTOP + NSIDE + i];
        end
    endtask

    task automatic model_clear();
        exp_top = '0; exp_bottom = '0; exp_left = '0; exp_right = '0;
    endtask

    task automatic gap_cycles(input int gap_mode, input int n);
        int g;
        g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(2)) * int'($urandom_range(1)) : 0;
        if (n == 0) g = 0;
        for (int j = 0; j < g; j++) begin
            cfg_valid = 1'b0;
            cfg_din   = 1'($urandom);
            tick();
            chk("busy_gap", 64'(cfg_busy), 64'd1);
        end
    endtask

    // gap_mode: 0 continuous, 1 idle cycle before every bit, 2 random idles.
    task automatic send_frame(input string tag, input frame_t f, input int gap_mode,
                              input bit flip_par, input bit poke_commit);
        bit legal, par;
        int n;
        logic [5:0] w;
        legal = 1'b1;
        par   = 1'b0;
        n     = 0;
        for (int k = 0; k < NW; k++) if (!word_ok(f[k])) legal = 1'b0;
        cfg_start = 1'b1;
        cfg_valid = 1'($urandom);
        cfg_din   = 1'($urandom);
        tick();
        cfg_start = 1'b0;
        chk({tag, "_busy_start"}, 64'(cfg_busy), 64'd1);
        chk({tag, "_err_clear"},  64'(cfg_err),  64'd0);
        for (int k = 0; k < NW; k++) begin
            w = f[k];
            for (int b = 5; b >= 0; b--) begin
                gap_cycles(gap_mode, n);
                cfg_valid = 1'b1;
                cfg_din   = w[b];
                par       = par ^ w[b];
                tick();
                n++;
`ifndef CFG_PARITY_EN
                if (n < NW*6)
`endif
                    chk("busy_load", 64'(cfg_busy), 64'd1);
            end
        end
`ifdef CFG_PARITY_EN
        gap_cycles(gap_mode, n);
        cfg_valid = 1'b1;
        cfg_din   = par ^ flip_par;
        tick();
        if (flip_par) legal = 1'b0;
`else
        if (flip_par) legal = legal;
`endif
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;
        if (legal) begin
            chk({tag, "_done_early"}, 64'(cfg_done), 64'd0);
            if (poke_commit) cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
            model_commit(f);
            chk({tag, "_done"},      64'(cfg_done), 64'd1);
            chk({tag, "_err_ok"},    64'(cfg_err),  64'd0);
            chk({tag, "_busy_done"}, 64'(cfg_busy), 64'd0);
            chk_buses(tag);
            tick();
            chk({tag, "_done_1cyc"}, 64'(cfg_done), 64'd0);
            chk({tag, "_idle_busy"}, 64'(cfg_busy), 64'd0);
        end else begin
            chk({tag, "_err"},       64'(cfg_err),  64'd1);
            chk({tag, "_busy_err"},  64'(cfg_busy), 64'd0);
            chk({tag, "_no_done"},   64'(cfg_done), 64'd0);
            tick();
            chk({tag, "_no_done2"},  64'(cfg_done), 64'd0);
            chk({tag, "_err_hold"},  64'(cfg_err),  64'd1);
            chk_buses({tag, "_kept"});
        end
    endtask

    task automatic partial_bits(input int nbits);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            cfg_valid = 1'b1;
            cfg_din   = 1'($urandom);
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        frame_t f;
        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_din = 1'b0;
        model_clear();

        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 64'(cfg_busy), 64'd0);
        chk("rst_done", 64'(cfg_done), 64'd0);
        chk("rst_err",  64'(cfg_err),  64'd0);
        chk_buses("rst");

        // Valid bits in IDLE without a start must be ignored.
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b1; cfg_din = 1'b1; tick();
            chk("idle_busy", 64'(cfg_busy), 64'd0);
        end
        cfg_valid = 1'b0;
        chk_buses("idle_ignore");

        f = zero_frame();
        f[0] = 6'b001_010;
        send_frame("single", f, 0, 1'b0, 1'b0);
        chk("single_top0", 64'(cfg_top[5:0]), 64'h0A);

        send_frame("gaps", f, 1, 1'b0, 1'b0);

        f = rand_frame(1'b0);
        send_frame("frameA", f, 2, 1'b0, 1'b0);
        f[2*NTOP + 2] = 6'b000_101;
        send_frame("bad_side", f, 2, 1'b0, 1'b0);

        f = rand_frame(1'b0);
        f[2*NTOP + NSIDE] = 6'b101_010;
        send_frame("bad_idx", f, 0, 1'b0, 1'b0);
        f = rand_frame(1'b0);
        send_frame("recover", f, 0, 1'b0, 1'b1);

        partial_bits(50);
        f = rand_frame(1'b0);
        send_frame("restart", f, 2, 1'b0, 1'b0);

        partial_bits(70);
        rst = 1'b1; tick(); rst = 1'b0;
        model_clear();
        chk("midrst_busy", 64'(cfg_busy), 64'd0);
        chk("midrst_err",  64'(cfg_err),  64'd0);
        chk_buses("midrst");
        for (int i = 0; i < 6; i++) begin
            cfg_valid = 1'b1; cfg_din = 1'($urandom); tick();
            chk("midrst_idle", 64'(cfg_busy), 64'd0);
        end
        cfg_valid = 1'b0;
        f = rand_frame(1'b0);
        send_frame("after_rst", f, 0, 1'b0, 1'b0);

`ifdef CFG_PARITY_EN
        f = rand_frame(1'b0);
        send_frame("par_flip", f, 2, 1'b1, 1'b0);
`endif

        for (int r = 0; r < 24; r++) begin
            f = rand_frame(1'b1);
            send_frame("rand", f, 2, ($urandom_range(7) == 0), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
